// File: rtl/vga_control.sv
// VGA timing and pixel-output controller: free-running h/v counters, active-low syncs,
// gated RGB output and a double-buffered timing register file loaded at the frame wrap.
module vga_control #(
    parameter int unsigned CONFIG_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH        = 12,
    parameter int unsigned COLOR_WIDTH       = 4,
    parameter int unsigned H_Left_Margin_RD  = 1,
    parameter int unsigned V_Left_Margin_RD  = 2,
    parameter int unsigned H_Right_Margin_RD = 7,
    parameter int unsigned V_Right_Margin_RD = 8,
    parameter int unsigned H_Sync_Pulse_RD   = 1,
    parameter int unsigned V_Sync_Pulse_RD   = 0,
    parameter int unsigned H_Count_Max_RD    = 10,
    parameter int unsigned V_Count_Max_RD    = 12
) (
    input  logic                    Clk,
    input  logic                    rst_n,
    input  logic                    C_valid,
    input  logic [CONFIG_WIDTH-1:0] C_addr,
    input  logic [CONFIG_WIDTH-1:0] C_data,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    output logic                    C_rdy,
    output logic                    HSync,
    output logic                    VSync,
    output logic [COLOR_WIDTH-1:0]  Red,
    output logic [COLOR_WIDTH-1:0]  Green,
    output logic [COLOR_WIDTH-1:0]  Blue
);

    localparam logic [2:0] RegHLeft  = 3'd0;
    localparam logic [2:0] RegVLeft  = 3'd1;
    localparam logic [2:0] RegHRight = 3'd2;
    localparam logic [2:0] RegVRight = 3'd3;
    localparam logic [2:0] RegHSync  = 3'd4;
    localparam logic [2:0] RegVSync  = 3'd5;
    localparam logic [2:0] RegHMax   = 3'd6;
    localparam logic [2:0] RegVMax   = 3'd7;

    localparam logic [CONFIG_WIDTH-1:0] NumRegs = CONFIG_WIDTH'(8);
    localparam logic [CONFIG_WIDTH-1:0] One     = CONFIG_WIDTH'(1);

    localparam logic [CONFIG_WIDTH-1:0] ResetVals [8] = '{
        CONFIG_WIDTH'(H_Left_Margin_RD),
        CONFIG_WIDTH'(V_Left_Margin_RD),
        CONFIG_WIDTH'(H_Right_Margin_RD),
        CONFIG_WIDTH'(V_Right_Margin_RD),
        CONFIG_WIDTH'(H_Sync_Pulse_RD),
        CONFIG_WIDTH'(V_Sync_Pulse_RD),
        CONFIG_WIDTH'(H_Count_Max_RD),
        CONFIG_WIDTH'(V_Count_Max_RD)
    };

    logic [CONFIG_WIDTH-1:0] pend_q [8];
    logic [CONFIG_WIDTH-1:0] pend_d [8];
    logic [CONFIG_WIDTH-1:0] act_q  [8];
    logic [CONFIG_WIDTH-1:0] act_d  [8];

    logic [CONFIG_WIDTH-1:0] h_q, h_d;
    logic [CONFIG_WIDTH-1:0] v_q, v_d;
    logic                    rdy_q, rdy_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic [COLOR_WIDTH-1:0]  red_q, red_d;
    logic [COLOR_WIDTH-1:0]  green_q, green_d;
    logic [COLOR_WIDTH-1:0]  blue_q, blue_d;

    logic accept;
    logic h_wrap;
    logic v_wrap;
    logic frame_wrap;
    logic visible;

    always_comb begin
        accept = C_valid && rdy_q;
        rdy_d  = ~accept;

        pend_d = pend_q;
        if (accept && (C_addr < NumRegs)) begin
            pend_d[C_addr[2:0]] = C_data;
        end

        // >= rather than == so a shrunk maximum can never strand the counters.
        h_wrap     = h_q >= act_q[RegHMax];
        v_wrap     = v_q >= act_q[RegVMax];
        frame_wrap = h_wrap && v_wrap;

        // Using pend_d lets a write accepted on the wrap cycle join this copy.
        act_d = frame_wrap ? pend_d : act_q;

        h_d = h_wrap ? '0 : h_q + One;
        v_d = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + One;
        end

        hsync_d = ~(h_q < act_q[RegHSync]);
        vsync_d = ~(v_q < act_q[RegVSync]);

        visible = (h_q >= act_q[RegHLeft]) && (h_q < act_q[RegHRight]) &&
                  (v_q >= act_q[RegVLeft]) && (v_q < act_q[RegVRight]);

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (visible) begin
            red_d   = Data_in[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
            green_d = Data_in[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
            blue_d  = Data_in[COLOR_WIDTH-1 -: COLOR_WIDTH];
        end
    end

    // rst_n is an active-high synchronous reset despite its name.
    always_ff @(posedge Clk) begin
        if (rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            pend_q  <= ResetVals;
            act_q   <= ResetVals;
            rdy_q   <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            rdy_q   <= rdy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign C_rdy = rdy_q;
    assign HSync = hsync_q;
    assign VSync = vsync_q;
    assign Red   = red_q;
    assign Green = green_q;
    assign Blue  = blue_q;

endmodule

// File: tb/tb_vga_control.sv
// Directed bench for vga_control: counts sync/pixel activity over whole frames and
// checks individual pixels and handshake cycles against hand-computed positions.
module tb_vga_control;

    logic        Clk;
    logic        rst_n;
    logic        C_valid;
    logic [9:0]  C_addr;
    logic [9:0]  C_data;
    logic [11:0] Data_in;
    logic        C_rdy;
    logic        HSync;
    logic        VSync;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;

    int cyc;
    int n_checks;
    int n_pass;

    // Measurement results of the most recent measure() call.
    int hs_lo, vs_lo, rgb_on, rgb_bad, first_hs, second_hs, first_vs;

    vga_control dut (
        .Clk     (Clk),
        .rst_n   (rst_n),
        .C_valid (C_valid),
        .C_addr  (C_addr),
        .C_data  (C_data),
        .Data_in (Data_in),
        .C_rdy   (C_rdy),
        .HSync   (HSync),
        .VSync   (VSync),
        .Red     (Red),
        .Green   (Green),
        .Blue    (Blue)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // cyc counts rising edges since reset release; outputs after edge cyc show position cyc-1.
    task automatic step();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic measure(input int n);
        logic [11:0] rgb;
        hs_lo = 0; vs_lo = 0; rgb_on = 0; rgb_bad = 0;
        first_hs = -1; second_hs = -1; first_vs = -1;
        for (int i = 0; i < n; i++) begin
            step();
            rgb = {Red, Green, Blue};
            if (HSync == 1'b0) begin
                if (hs_lo == 0) first_hs = cyc;
                if (hs_lo == 1) second_hs = cyc;
                hs_lo++;
            end
            if (VSync == 1'b0) begin
                if (vs_lo == 0) first_vs = cyc;
                vs_lo++;
            end
            if (rgb != 12'h000) begin
                rgb_on++;
                if (rgb != Data_in) rgb_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        Data_in = 12'hAFA;
        C_valid = 1'b1;
        C_addr  = 10'd5;
        C_data  = 10'd9;
        step();
        step();
        n_checks++; if (HSync !== 1'b1) $display("FAIL reset_hsync got %b want 1", HSync); else n_pass++;
        n_checks++; if (VSync !== 1'b1) $display("FAIL reset_vsync got %b want 1", VSync); else n_pass++;
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL reset_rgb got %h want 000", {Red, Green, Blue}); else n_pass++;
        n_checks++; if (C_rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", C_rdy); else n_pass++;
        C_valid = 1'b0;
        rst_n   = 1'b0;
        cyc     = 0;
        step();
        n_checks++; if (C_rdy !== 1'b1) $display("FAIL release_rdy got %b want 1", C_rdy); else n_pass++;
        n_checks++; if (HSync !== 1'b0) $display("FAIL release_hsync got %b want 0", HSync); else n_pass++;
    endtask

    task automatic test_defaults();
        measure(143);
        n_checks++; if (hs_lo !== 13) $display("FAIL dflt_hs_count got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (first_hs !== 12) $display("FAIL dflt_hs_first got %0d want 12", first_hs); else n_pass++;
        n_checks++; if (second_hs !== 23) $display("FAIL dflt_line_period got %0d want 23", second_hs); else n_pass++;
        n_checks++; if (vs_lo !== 0) $display("FAIL dflt_vs_count got %0d want 0", vs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 36) $display("FAIL dflt_rgb_count got %0d want 36", rgb_on); else n_pass++;
        n_checks++; if (rgb_bad !== 0) $display("FAIL dflt_rgb_value got %0d bad want 0", rgb_bad); else n_pass++;
    endtask

    // Frame 1 spans positions 143..285, so in-frame position p is sampled at cyc 144+p.
    task automatic test_visible();
        goto(158);
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL vis_row1 got %h want 000", {Red, Green, Blue}); else n_pass++;
        goto(166);
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL vis_h0 got %h want 000", {Red, Green, Blue}); else n_pass++;
        goto(167);
        n_checks++; if ({Red, Green, Blue} !== 12'hAFA)
            $display("FAIL vis_first got %h want afa", {Red, Green, Blue}); else n_pass++;
        Data_in = 12'h3C5;
        goto(172);
        n_checks++; if (Red !== 4'h3) $display("FAIL vis_red got %h want 3", Red); else n_pass++;
        n_checks++; if (Green !== 4'hC) $display("FAIL vis_green got %h want c", Green); else n_pass++;
        n_checks++; if (Blue !== 4'h5) $display("FAIL vis_blue got %h want 5", Blue); else n_pass++;
        goto(173);
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL vis_h7 got %h want 000", {Red, Green, Blue}); else n_pass++;
        goto(227);
        n_checks++; if ({Red, Green, Blue} !== 12'h3C5)
            $display("FAIL vis_last got %h want 3c5", {Red, Green, Blue}); else n_pass++;
        goto(233);
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL vis_row8 got %h want 000", {Red, Green, Blue}); else n_pass++;
    endtask

    task automatic test_config_write();
        n_checks++; if (C_rdy !== 1'b1) $display("FAIL cfg_rdy_before got %b want 1", C_rdy); else n_pass++;
        C_valid = 1'b1;
        C_addr  = 10'd5;
        C_data  = 10'd3;
        step();
        n_checks++; if (C_rdy !== 1'b0) $display("FAIL cfg_rdy_drop got %b want 0", C_rdy); else n_pass++;
        // Presented while not ready: must be ignored.
        C_addr = 10'd4;
        C_data = 10'd7;
        step();
        n_checks++; if (C_rdy !== 1'b1) $display("FAIL cfg_rdy_back got %b want 1", C_rdy); else n_pass++;
        C_valid = 1'b0;
        measure(51);
        n_checks++; if (vs_lo !== 0) $display("FAIL cfg_cur_frame_vs got %0d want 0", vs_lo); else n_pass++;
        measure(143);
        n_checks++; if (vs_lo !== 33) $display("FAIL cfg_next_vs_count got %0d want 33", vs_lo); else n_pass++;
        n_checks++; if (first_vs !== 287) $display("FAIL cfg_next_vs_first got %0d want 287", first_vs); else n_pass++;
        n_checks++; if (hs_lo !== 13) $display("FAIL cfg_busy_write_hs got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 36) $display("FAIL cfg_rgb_count got %0d want 36", rgb_on); else n_pass++;
    endtask

    task automatic test_unmapped();
        C_valid = 1'b1;
        C_addr  = 10'd11;
        C_data  = 10'd2;
        step();
        n_checks++; if (C_rdy !== 1'b0) $display("FAIL unmap_rdy_drop got %b want 0", C_rdy); else n_pass++;
        C_valid = 1'b0;
        step();
        n_checks++; if (C_rdy !== 1'b1) $display("FAIL unmap_rdy_back got %b want 1", C_rdy); else n_pass++;
        goto(572);
        measure(143);
        n_checks++; if (hs_lo !== 13) $display("FAIL unmap_hs got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (vs_lo !== 33) $display("FAIL unmap_vs got %0d want 33", vs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 36) $display("FAIL unmap_rgb got %0d want 36", rgb_on); else n_pass++;
        n_checks++; if (rgb_bad !== 0) $display("FAIL unmap_rgb_value got %0d want 0", rgb_bad); else n_pass++;
    endtask

    // Frame 5 starts at position 715; position 723 is h=8, v=0.
    task automatic test_shrink();
        goto(723);
        C_valid = 1'b1;
        C_addr  = 10'd6;
        C_data  = 10'd4;
        step();
        C_valid = 1'b0;
        measure(134);
        n_checks++; if (hs_lo !== 12) $display("FAIL shrink_cur_hs got %0d want 12", hs_lo); else n_pass++;
        n_checks++; if (vs_lo !== 24) $display("FAIL shrink_cur_vs got %0d want 24", vs_lo); else n_pass++;
        measure(65);
        n_checks++; if (hs_lo !== 13) $display("FAIL shrink_hs got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (first_hs !== 859) $display("FAIL shrink_hs_first got %0d want 859", first_hs); else n_pass++;
        n_checks++; if (second_hs !== 864) $display("FAIL shrink_period got %0d want 864", second_hs); else n_pass++;
        n_checks++; if (vs_lo !== 15) $display("FAIL shrink_vs got %0d want 15", vs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 24) $display("FAIL shrink_rgb got %0d want 24", rgb_on); else n_pass++;
        measure(65);
        n_checks++; if (hs_lo !== 13) $display("FAIL shrink_repeat_hs got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (vs_lo !== 15) $display("FAIL shrink_repeat_vs got %0d want 15", vs_lo); else n_pass++;
    endtask

    task automatic test_reset_mid();
        C_valid = 1'b1;
        C_addr  = 10'd6;
        C_data  = 10'd10;
        step();
        C_valid = 1'b0;
        step();
        C_valid = 1'b1;
        C_addr  = 10'd0;
        C_data  = 10'd3;
        step();
        C_valid = 1'b0;
        // Frame 9 (positions 1053..) runs an 11-clock line with H_Left_Margin=3.
        goto(1053);
        measure(71);
        n_checks++; if (hs_lo !== 7) $display("FAIL mid_hs got %0d want 7", hs_lo); else n_pass++;
        n_checks++; if (vs_lo !== 33) $display("FAIL mid_vs got %0d want 33", vs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 18) $display("FAIL mid_rgb got %0d want 18", rgb_on); else n_pass++;
        rst_n   = 1'b1;
        C_valid = 1'b1;
        C_addr  = 10'd5;
        C_data  = 10'd9;
        step();
        step();
        n_checks++; if (HSync !== 1'b1) $display("FAIL mid_rst_hsync got %b want 1", HSync); else n_pass++;
        n_checks++; if (VSync !== 1'b1) $display("FAIL mid_rst_vsync got %b want 1", VSync); else n_pass++;
        n_checks++; if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL mid_rst_rgb got %h want 000", {Red, Green, Blue}); else n_pass++;
        n_checks++; if (C_rdy !== 1'b0) $display("FAIL mid_rst_rdy got %b want 0", C_rdy); else n_pass++;
        rst_n   = 1'b0;
        C_valid = 1'b0;
        cyc     = 0;
        step();
        n_checks++; if (C_rdy !== 1'b1) $display("FAIL mid_rel_rdy got %b want 1", C_rdy); else n_pass++;
        n_checks++; if (HSync !== 1'b0) $display("FAIL mid_rel_hsync got %b want 0", HSync); else n_pass++;
        measure(143);
        n_checks++; if (hs_lo !== 13) $display("FAIL mid_dflt_hs got %0d want 13", hs_lo); else n_pass++;
        n_checks++; if (second_hs !== 23) $display("FAIL mid_dflt_period got %0d want 23", second_hs); else n_pass++;
        n_checks++; if (vs_lo !== 0) $display("FAIL mid_dflt_vs got %0d want 0", vs_lo); else n_pass++;
        n_checks++; if (rgb_on !== 36) $display("FAIL mid_dflt_rgb got %0d want 36", rgb_on); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst_n    = 1'b1;
        C_valid  = 1'b0;
        C_addr   = '0;
        C_data   = '0;
        Data_in  = '0;
        test_reset();
        test_defaults();
        test_visible();
        test_config_write();
        test_unmapped();
        test_shrink();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
